// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory handshake, 1-entry fetch buffer, IF/ID register.
// Optional perf counters (perf_fetched/perf_bubbles) are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int unsigned        PC_W      = 8,
  parameter int unsigned        INSTR_W   = 16,
  parameter int unsigned        PC_INC    = 2,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out,
  output logic [3:0]         opcode,
  output logic [3:0]         rd1,
  output logic [3:0]         rd2,
  output logic [3:0]         funct,
  output logic [11:0]        offset
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_bubbles
`endif
);

  localparam logic [PC_W-1:0] INC      = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] PC_ALIGN = ~PC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               vld;
  } ifid_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, kill_addr_q;
  logic               kill_q;
  logic [INSTR_W-1:0] buf_q;
  ifid_t              ifid_q;

  logic               in_fetch, in_hold;
  logic               data_ok, load_ack, to_buf, load_buf, load;
  logic [INSTR_W-1:0] load_instr;
  logic [PC_W-1:0]    pc_inc, br_pc;

  assign in_fetch   = (state_q == S_FETCH);
  assign in_hold    = (state_q == S_HOLD);
  assign pc_inc     = pc_q + INC;
  assign br_pc      = branch_target & PC_ALIGN;

  // Returned data is usable only if no redirect killed it (pending or this cycle).
  assign data_ok    = in_fetch && im_ack && !kill_q && !branch_taken;
  assign load_ack   = data_ok && !stall;
  assign to_buf     = data_ok && stall;
  assign load_buf   = in_hold && !stall && !branch_taken;
  assign load       = load_ack || load_buf;
  assign load_instr = in_hold ? buf_q : im_rdata;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (to_buf) state_d = S_HOLD;
      S_HOLD:  if (branch_taken || !stall) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // While a killed request is in flight the old address stays on the bus until acked.
  always_comb begin
    im_req  = 1'b0;
    im_addr = pc_q;
    if (in_fetch) im_req = 1'b1;
    if (kill_q)   im_addr = kill_addr_q;
  end

  // ---------------- PC, kill, fetch buffer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      kill_addr_q <= RESET_PC;
      buf_q       <= NOP_INSTR;
    end else begin
      if (branch_taken) pc_q <= br_pc;
      else if (load)    pc_q <= pc_inc;

      if (in_fetch && im_ack)            kill_q <= 1'b0;
      else if (in_fetch && branch_taken) kill_q <= 1'b1;

      if (in_fetch && branch_taken && !im_ack && !kill_q) kill_addr_q <= pc_q;

      if (to_buf) buf_q <= im_rdata;
    end
  end

  // ---------------- IF/ID register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q <= '{instr: NOP_INSTR, pc: '0, vld: 1'b0};
    end else if (branch_taken) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.vld   <= 1'b0;
    end else if (load) begin
      ifid_q <= '{instr: load_instr, pc: pc_inc, vld: 1'b1};
    end else if (!stall) begin
      // Decode consumed the previous entry; nothing new is ready, so insert a bubble.
      ifid_q.instr <= NOP_INSTR;
      ifid_q.vld   <= 1'b0;
    end
  end

  assign instr_out = ifid_q.instr;
  assign pc_out    = ifid_q.pc;
  assign valid_out = ifid_q.vld;
  assign opcode    = ifid_q.instr[15:12];
  assign rd1       = ifid_q.instr[11:8];
  assign rd2       = ifid_q.instr[7:4];
  assign funct     = ifid_q.instr[3:0];
  assign offset    = ifid_q.instr[11:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (load && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (!ifid_q.vld && !stall && perf_bubbles != 16'hFFFF) perf_bubbles <= perf_bubbles + 16'd1;
    end
  end
`endif

  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (im_req && !im_ack) |=> (im_addr == $past(im_addr)));

endmodule
